// File: rtl/fetch_stream_pkg.sv
// Types shared by the fetch-stream line buffer and its request tracker.
package fetch_stream_pkg;

  // Which rule produced this cycle's memory request.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MISS = 2'd1,
    SRC_PRED = 2'd2,
    SRC_LR   = 2'd3
  } req_src_e;

  // Candidate slots outside the prediction window: one demand miss, one link-register hint.
  localparam int REQ_SRC_FIXED = 2;

endpackage

// File: rtl/fetch_inflight.sv
// Shift pipeline of outstanding line requests with address match against candidates.
module fetch_inflight
  import fetch_stream_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int STAGES = 3,
  parameter int N_CMP  = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    i_issue,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [N_CMP*ADDR_W-1:0] i_cmp_addr,
  output logic [N_CMP-1:0]        o_match,
  output logic                    o_head_vld,
  output logic                    o_ret_vld,
  output logic [ADDR_W-1:0]       o_ret_addr
);

  logic [STAGES-1:0] r_vld;
  logic [ADDR_W-1:0] r_addr [STAGES];

  // Stage 0 is the request on the memory bus; the last stage is the line returning now.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[STAGES-2:0], i_issue};
    end
  end

  always_ff @(posedge clk) begin
    r_addr[0] <= i_addr;
    for (int s = 1; s < STAGES; s++) begin
      r_addr[s] <= r_addr[s-1];
    end
  end

  always_comb begin
    o_match = '0;
    for (int c = 0; c < N_CMP; c++) begin
      for (int s = 0; s < STAGES; s++) begin
        if (r_vld[s] && (r_addr[s] == i_cmp_addr[c*ADDR_W +: ADDR_W])) begin
          o_match[c] = 1'b1;
        end
      end
    end
  end

  assign o_head_vld = r_vld[0];
  assign o_ret_vld  = r_vld[STAGES-1];
  assign o_ret_addr = r_addr[STAGES-1];

endmodule

// File: rtl/fetch_stream.sv
// Instruction line buffer with per-port lookup, sequential prefetch and link-register hint.
`ifndef LEN_WORD
`define LEN_WORD 32
`endif
`ifndef LEN_INST
`define LEN_INST 32
`endif
`ifndef LEN_MEMISTR_ADDR
`define LEN_MEMISTR_ADDR 12
`endif
`ifndef LOG_FETCH_PARA
`define LOG_FETCH_PARA 1
`endif
`ifndef DECODE_PARA
`define DECODE_PARA 2
`endif

module fetch_stream
  import fetch_stream_pkg::*;
#(
  parameter int LEN_MEMISTR_ADDR = `LEN_MEMISTR_ADDR,
  parameter int LOG_FETCH_PARA   = `LOG_FETCH_PARA,
  parameter int N_PORT           = `DECODE_PARA,
  parameter int DEPTH            = 8,
  parameter int MEM_LATENCY      = 2,
  parameter int PREDICT_DEPTH    = 3
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [N_PORT-1:0]                         order,
  input  logic [`LEN_WORD*N_PORT-1:0]               pc,
  output logic [N_PORT-1:0]                         done,
  output logic [`LEN_INST*N_PORT-1:0]               instr,
  input  logic [`LEN_WORD-1:0]                      lr_d,
  input  logic                                      flush,
  output logic                                      mem_req,
  output logic [LEN_MEMISTR_ADDR-1:0]               a_inst_mem,
  input  logic [`LEN_INST*(2**LOG_FETCH_PARA)-1:0]  d_inst_mem_r
);

  localparam int FETCH_PARA = 2**LOG_FETCH_PARA;
  localparam int AW         = LEN_MEMISTR_ADDR;
  localparam int IW         = `LEN_INST;
  localparam int WW         = `LEN_WORD;
  localparam int LW         = IW * FETCH_PARA;
  localparam int VW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NCAND      = PREDICT_DEPTH + REQ_SRC_FIXED;
  localparam int STAGES     = MEM_LATENCY + 1;
  localparam int LSB        = LOG_FETCH_PARA + 2;

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_tag  [DEPTH];
  logic [LW-1:0]    r_data [DEPTH];
  logic [VW-1:0]    r_victim;
  logic [AW-1:0]    r_last_found;
  logic [AW-1:0]    r_a_inst_mem;

  logic [AW-1:0]             w_line [N_PORT];
  logic [LOG_FETCH_PARA-1:0] w_off  [N_PORT];
  logic [AW-1:0]             w_lr_line;
  logic [N_PORT-1:0]         w_hit;
  logic [LW-1:0]             w_hit_data [N_PORT];
  logic                      w_unused;

  logic          w_miss_any, w_hit_any;
  logic [AW-1:0] w_miss_line, w_hit_line, w_base;

  logic [AW-1:0]       w_cand [NCAND];
  logic [NCAND-1:0]    w_cand_en, w_cand_buf, w_cand_fly;
  logic [NCAND*AW-1:0] w_cand_flat;

  req_src_e      w_src;
  logic [AW-1:0] w_req_addr;
  logic          w_issue;
  logic          w_head_vld, w_ret_vld, w_fill;
  logic [AW-1:0] w_ret_addr;

  // PC and hint decode; byte-offset and high PC bits do not address the buffer.
  always_comb begin
    for (int i = 0; i < N_PORT; i++) begin
      w_line[i] = pc[i*WW+LSB +: AW];
      w_off[i]  = pc[i*WW+2 +: LOG_FETCH_PARA];
    end
    w_lr_line = lr_d[LSB +: AW];
  end

  assign w_unused = ^{pc, lr_d};

  // Lookup: first instruction of a line sits in the most significant slice.
  always_comb begin
    done  = '0;
    instr = '0;
    for (int i = 0; i < N_PORT; i++) begin
      w_hit[i]      = 1'b0;
      w_hit_data[i] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (r_valid[e] && (r_tag[e] == w_line[i])) begin
          w_hit[i]      = 1'b1;
          w_hit_data[i] = r_data[e];
        end
      end
      done[i] = order[i] & w_hit[i];
      for (int j = 0; j < FETCH_PARA; j++) begin
        if (done[i] && (int'(w_off[i]) == FETCH_PARA-1-j)) begin
          instr[i*IW +: IW] = w_hit_data[i][j*IW +: IW];
        end
      end
    end
  end

  always_comb begin
    w_miss_any  = 1'b0;
    w_miss_line = '0;
    for (int i = N_PORT-1; i >= 0; i--) begin
      if (order[i] && !w_hit[i]) begin
        w_miss_any  = 1'b1;
        w_miss_line = w_line[i];
      end
    end
    w_hit_any  = 1'b0;
    w_hit_line = '0;
    for (int i = 0; i < N_PORT; i++) begin
      if (done[i]) begin
        w_hit_any  = 1'b1;
        w_hit_line = w_line[i];
      end
    end
    w_base = w_miss_any ? w_miss_line : (w_hit_any ? w_hit_line : r_last_found);
  end

  // Candidate order: demand miss, then base+1..base+PREDICT_DEPTH, then the hint.
  always_comb begin
    w_cand[0]    = w_miss_line;
    w_cand_en[0] = w_miss_any;
    for (int j = 1; j <= PREDICT_DEPTH; j++) begin
      w_cand[j]    = w_base + AW'(j);
      w_cand_en[j] = 1'b1;
    end
    w_cand[NCAND-1]    = w_lr_line;
    w_cand_en[NCAND-1] = 1'b1;
    for (int c = 0; c < NCAND; c++) begin
      w_cand_buf[c] = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        if (r_valid[e] && (r_tag[e] == w_cand[c])) begin
          w_cand_buf[c] = 1'b1;
        end
      end
      w_cand_flat[c*AW +: AW] = w_cand[c];
    end
  end

  always_comb begin
    w_src      = SRC_NONE;
    w_req_addr = r_a_inst_mem;
    for (int c = NCAND-1; c >= 0; c--) begin
      if (w_cand_en[c] && !w_cand_buf[c] && !w_cand_fly[c]) begin
        w_req_addr = w_cand[c];
        if (c == 0) begin
          w_src = SRC_MISS;
        end else if (c == NCAND-1) begin
          w_src = SRC_LR;
        end else begin
          w_src = SRC_PRED;
        end
      end
    end
    w_issue = (w_src != SRC_NONE) && !flush;
  end

  fetch_inflight #(
    .ADDR_W (AW),
    .STAGES (STAGES),
    .N_CMP  (NCAND)
  ) u_inflight (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .i_issue    (w_issue),
    .i_addr     (w_req_addr),
    .i_cmp_addr (w_cand_flat),
    .o_match    (w_cand_fly),
    .o_head_vld (w_head_vld),
    .o_ret_vld  (w_ret_vld),
    .o_ret_addr (w_ret_addr)
  );

  assign w_fill = w_ret_vld & ~flush;

  // Control state; the victim pointer survives a flush so replacement keeps rotating.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid      <= '0;
      r_victim     <= '0;
      r_last_found <= '0;
      r_a_inst_mem <= '0;
    end else begin
      if (w_issue) begin
        r_a_inst_mem <= w_req_addr;
      end
      if (flush) begin
        r_valid      <= '0;
        r_last_found <= '0;
      end else begin
        if (w_fill) begin
          r_valid[r_victim] <= 1'b1;
          r_victim          <= (r_victim == VW'(DEPTH-1)) ? '0 : r_victim + 1'b1;
        end
        if (w_hit_any) begin
          r_last_found <= w_hit_line;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[r_victim]  <= w_ret_addr;
      r_data[r_victim] <= d_inst_mem_r;
    end
  end

  assign mem_req    = w_head_vld;
  assign a_inst_mem = r_a_inst_mem;

endmodule
